ram_sdp_be: RTL and testbench

//  Simple-dual-port RAM: one write port and one read port on a single clock.
//  - Byte-enabled writes.
//  - Read latency of 1 or 2 cycles, with a read-data valid strobe.
//  - Collision behaviour selectable between write-first and read-first.
//  - Optional hardware clear of the whole array after reset.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_rd_pipe.sv | 35 +++
 rtl/ram_sdp_be.sv | 120 ++++++++++++
 tb/tb_ram_sdp_be.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enabled RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Collision modes for the WRITE_FIRST parameter.
    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    // Parameter-dependent widths (BYTES, CNT_W) are derived through these helpers.
    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line: LATENCY register stages carrying data plus a valid bit.
module ram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] vld;
    logic [WIDTH-1:0]   dat [LATENCY];

    // Data stages only load behind a valid bit, so the output holds its last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enabled writes, selectable collision mode,
// 1- or 2-cycle read latency and optional zero-fill of the array after reset.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int DEPTH         = 2**ADDR_WIDTH,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_FIRST   = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    ready
);

    localparam int                  BYTES     = byte_count(DATA_WIDTH);
    localparam int                  CNT_W     = cnt_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0]    LAST_WORD = CNT_W'(DEPTH - 1);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $error("ram_sdp_be: DEPTH must not exceed 2**ADDR_WIDTH");
    end

    ram_state_e       state;
    logic [CNT_W-1:0] cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range, rd_in_range;
    logic             wr_ok, rd_ok, collide;
    logic [CNT_W-1:0] wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
    assign wr_idx      = wr_addr[CNT_W-1:0];
    assign rd_idx      = rd_addr[CNT_W-1:0];
    assign wr_ok       = ready && we && wr_in_range;
    assign rd_ok       = ready && re;
    assign collide     = wr_ok && (wr_addr == rd_addr);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (INIT_ON_RESET != 0) state <= CLEAR;
            else                    state <= READY;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_WORD) begin
                        state <= READY;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: ready <= 1'b1;
                default: begin
                    state <= READY;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; zeroing is done word by word by the CLEAR state.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // NOTE: rd_word gets a default before any condition so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[rd_idx];
        if (WRITE_FIRST == COLL_WRITE_FIRST && collide) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    ram_rd_pipe #(
        .WIDTH   (DATA_WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_ok),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: three instances (latency 1 write-first, latency 2
// read-first, and a 12-word array) share one stimulus stream.
module tb_ram_sdp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, re;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;

    logic [31:0] rd_data_a, rd_data_b, rd_data_c;
    logic        rd_valid_a, rd_valid_b, rd_valid_c;
    logic        ready_a, ready_b, ready_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_mem [16];

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1),
                 .WRITE_FIRST(1), .INIT_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .re(re), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .ready(ready_a));

    ram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2),
                 .WRITE_FIRST(0), .INIT_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .re(re), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .ready(ready_b));

    ram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1),
                 .WRITE_FIRST(1), .INIT_ON_RESET(1)) u_c (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .re(re), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c), .ready(ready_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges after reset release until each instance raises ready.
    task automatic wait_ready(input int we_cycles, input string tag);
        int ca = 0, cb = 0, cc = 0;
        for (int cyc = 1; cyc <= 40 && (ca == 0 || cb == 0 || cc == 0); cyc++) begin
            @(posedge clk); #1;
            if (cyc == we_cycles) we = 1'b0;
            if (ready_a && ca == 0) ca = cyc;
            if (ready_b && cb == 0) cb = cyc;
            if (ready_c && cc == 0) cc = cyc;
        end
        check({tag, " clear cycles a"}, 32'(ca), 32'd16);
        check({tag, " clear cycles b"}, 32'(cb), 32'd16);
        check({tag, " clear cycles c"}, 32'(cc), 32'd12);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        we = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Single read, optionally with a same-address write in the same cycle.
    task automatic rd(input logic [3:0] addr, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ec, input bit coll = 1'b0,
                      input logic [31:0] wd = '0, input logic [3:0] be = '0);
        @(negedge clk);
        re = 1'b1; rd_addr = addr;
        if (coll) begin
            we = 1'b1; wr_addr = addr; wr_data = wd; wr_be = be;
        end
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        check($sformatf("rd_valid a @%0d", addr), 32'(rd_valid_a), 32'd1);
        check($sformatf("rd_data a @%0d", addr), rd_data_a, ea);
        check($sformatf("rd_valid c @%0d", addr), 32'(rd_valid_c), 32'd1);
        check($sformatf("rd_data c @%0d", addr), rd_data_c, ec);
        check($sformatf("rd_valid b early @%0d", addr), 32'(rd_valid_b), 32'd0);
        @(negedge clk);
        check($sformatf("rd_valid b @%0d", addr), 32'(rd_valid_b), 32'd1);
        check($sformatf("rd_data b @%0d", addr), rd_data_b, eb);
        check($sformatf("rd_valid a pulse @%0d", addr), 32'(rd_valid_a), 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), exp_mem[i], exp_mem[i], (i < 12) ? exp_mem[i] : 32'h0);
        end
        $display("%s readback done", tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset ready a", 32'(ready_a), 32'd0);
        check("reset ready c", 32'(ready_c), 32'd0);
        check("reset rd_valid b", 32'(rd_valid_b), 32'd0);
        check("reset rd_data a", rd_data_a, 32'h0);

        // Clear after reset, then all words read as zero
        @(negedge clk);
        rst = 1'b0;
        wait_ready(0, "initial");
        read_all("initial clear");

        // Byte-enable merge
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

        // Collision: write-first on a/c, read-first on b; array updated in all
        wr(4'd5, 32'hAAAAAAAA, 4'b1111);
        rd(4'd5, 32'hAAAA5555, 32'hAAAAAAAA, 32'hAAAA5555, 1'b1, 32'h55555555, 4'b0011);
        rd(4'd5, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555);

        // Back-to-back reads: a at latency 1, b at latency 2
        wr(4'd0, 32'd10, 4'b1111);
        wr(4'd1, 32'd20, 4'b1111);
        wr(4'd2, 32'd30, 4'b1111);
        begin
            logic [31:0] burst [3];
            burst[0] = 32'd10; burst[1] = 32'd20; burst[2] = 32'd30;
            @(negedge clk);
            re = 1'b1; rd_addr = 4'd0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k < 3) rd_addr = 4'(k);
                else       re = 1'b0;
                check($sformatf("burst valid a k%0d", k), 32'(rd_valid_a), (k <= 3) ? 32'd1 : 32'd0);
                if (k <= 3) check($sformatf("burst data a k%0d", k), rd_data_a, burst[k-1]);
                check($sformatf("burst valid b k%0d", k), 32'(rd_valid_b),
                      (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
                if (k >= 2 && k <= 4) check($sformatf("burst data b k%0d", k), rd_data_b, burst[k-2]);
            end
        end

        // Out-of-range on the 12-word instance: write dropped, read returns 0 with valid
        wr(4'd13, 32'hFFFFFFFF, 4'b1111);
        rd(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        exp_mem[0] = 32'd10; exp_mem[1] = 32'd20; exp_mem[2] = 32'd30;
        exp_mem[3] = 32'hDE22BE44; exp_mem[5] = 32'hAAAA5555; exp_mem[13] = 32'hFFFFFFFF;
        read_all("contents");

        // Reset with a read in flight on the latency-2 instance
        @(negedge clk);
        re = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        re = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("inflight rd_valid b", 32'(rd_valid_b), 32'd0);
        check("inflight rd_data b", rd_data_b, 32'h0);
        check("rst ready b", 32'(ready_b), 32'd0);
        @(posedge clk); #1;
        check("inflight rd_valid b later", 32'(rd_valid_b), 32'd0);

        // Reset halfway through the clear, with writes attempted during clear
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; wr_addr = 4'd3; wr_data = 32'h12345678; wr_be = 4'b1111;
        repeat (8) @(negedge clk);
        check("mid clear ready a", 32'(ready_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(9, "restart");
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
        read_all("restart clear");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
